// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_mem.
// slave = arbiter view, master = requesters + memory view.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic              lock0;
  logic              lock1;
  logic [ADDR_W-1:0] adr0;
  logic [ADDR_W-1:0] adr1;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, adr0, adr1, din0, din1, mem_dout,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, mem_adr, mem_we, mem_din
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, adr0, adr1, din0, din1, mem_dout,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, mem_adr, mem_we, mem_din
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for data_mem with bounded lock bursts.
// Optional stall counters enabled by defining DMEM_ARB_STATS_EN.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]        stall0,
  output logic [15:0]        stall1
`endif
);

  localparam int unsigned      CntW   = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(MAX_LOCK);
  localparam logic [CntW-1:0]  CntOne = CntW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_din;

  // Grant/FSM next-state. Nothing is granted while reset is held low.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (rst) begin
      case (state_q)
        StIdle: begin
          if (bus.req0 && (!bus.req1 || last_q)) begin
            gnt0   = 1'b1;
            last_d = 1'b0;
            if (bus.lock0) begin
              state_d    = StOwn0;
              lock_cnt_d = CntOne;
            end
          end else if (bus.req1) begin
            gnt1   = 1'b1;
            last_d = 1'b1;
            if (bus.lock1) begin
              state_d    = StOwn1;
              lock_cnt_d = CntOne;
            end
          end
        end
        StOwn0: begin
          if (bus.req0 && bus.lock0 && (lock_cnt_q < CntMax)) begin
            gnt0       = 1'b1;
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            // Final unlocked beat, forced release or bubble; last already points at 0.
            gnt0       = bus.req0 && !bus.lock0;
            state_d    = StIdle;
            lock_cnt_d = '0;
          end
        end
        StOwn1: begin
          if (bus.req1 && bus.lock1 && (lock_cnt_q < CntMax)) begin
            gnt1       = 1'b1;
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            gnt1       = bus.req1 && !bus.lock1;
            state_d    = StIdle;
            lock_cnt_d = '0;
          end
        end
        default: begin
          state_d    = StIdle;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  // Ungranted cycles present requester-0 values with the write strobe low.
  always_comb begin
    mem_adr = bus.adr0;
    mem_din = bus.din0;
    if (gnt1) begin
      mem_adr = bus.adr1;
      mem_din = bus.din1;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.mem_adr = mem_adr;
  assign bus.mem_din = mem_din;
  assign bus.mem_we  = (gnt0 & bus.we0) | (gnt1 & bus.we1);
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      ack0_q     <= gnt0;
      ack1_q     <= gnt1;
      if (gnt0 && !bus.we0) rdata0_q <= bus.mem_dout;
      if (gnt1 && !bus.we1) rdata1_q <= bus.mem_dout;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (bus.req0 && !gnt0 && (stall0_q != 16'hFFFF)) stall0_q <= stall0_q + 16'd1;
      if (bus.req1 && !gnt1 && (stall1_q != 16'hFFFF)) stall1_q <= stall1_q + 16'd1;
    end
  end

  assign stall0 = stall0_q;
  assign stall1 = stall1_q;
`else
  // Stall counters not built; arbitration is unchanged.
`endif

  a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));
  a_gnt_req   : assert property (@(posedge clk) (!gnt0 || bus.req0) && (!gnt1 || bus.req1));
  a_rst_no_we : assert property (@(posedge clk) !rst |-> !bus.mem_we);
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst) lock_cnt_q <= CntMax);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios then random traffic,
// compared cycle by cycle against an owner/beat-count reference model.
module tb_data_mem_arbiter;

  localparam int unsigned MaxLock = 4;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall0, stall1;
  int          m_stall0 = 0;
  int          m_stall1 = 0;
`endif

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_LOCK(MaxLock)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall0 (stall0),
    .stall1 (stall1)
`endif
  );

  // data_mem stand-in: combinational read, write on clock edge.
  logic [31:0] mem [256] = '{default: '0};
  assign bus.mem_dout = mem[bus.mem_adr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many beats it has taken, who won last.
  int          m_own  = -1;
  int          m_beats = 0;
  int          m_last = 1;
  logic        m_ack0 = 1'b0;
  logic        m_ack1 = 1'b0;
  logic [31:0] m_rd0  = '0;
  logic [31:0] m_rd1  = '0;
  logic [31:0] ref_mem [256] = '{default: '0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    logic r [2];
    logic l [2];
    r[0] = bus.req0;  r[1] = bus.req1;
    l[0] = bus.lock0; l[1] = bus.lock1;
    if (!rst) return -1;
    if (m_own < 0) begin
      if (r[0] && r[1]) return 1 - m_last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
    end
    if (r[m_own] && (!l[m_own] || m_beats < int'(MaxLock))) return m_own;
    return -1;
  endfunction

  function automatic void model_update(input int g);
    logic l [2];
    l[0] = bus.lock0; l[1] = bus.lock1;
    if (!rst) begin
      m_own = -1; m_beats = 0; m_last = 1;
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
`ifdef DMEM_ARB_STATS_EN
      m_stall0 = 0; m_stall1 = 0;
`endif
      return;
    end
    m_ack0 = (g == 0);
    m_ack1 = (g == 1);
    if (g == 0) begin
      if (bus.we0) ref_mem[bus.adr0] = bus.din0;
      else m_rd0 = ref_mem[bus.adr0];
    end
    if (g == 1) begin
      if (bus.we1) ref_mem[bus.adr1] = bus.din1;
      else m_rd1 = ref_mem[bus.adr1];
    end
`ifdef DMEM_ARB_STATS_EN
    if (bus.req0 && g != 0 && m_stall0 < 65535) m_stall0++;
    if (bus.req1 && g != 1 && m_stall1 < 65535) m_stall1++;
`endif
    if (m_own < 0) begin
      if (g >= 0) begin
        m_last = g;
        if (l[g]) begin m_own = g; m_beats = 1; end
      end
    end else if (g == m_own && l[m_own]) begin
      m_beats++;
    end else begin
      m_own = -1; m_beats = 0;
    end
  endfunction

  // One clock: check combinational outputs mid-cycle, advance, check registered outputs.
  // exp_g: hand-derived grant (-1 none, 0, 1) or -2 to rely on the model alone.
  task automatic cycle(input int exp_g);
    int          g;
    logic        we_exp;
    logic [31:0] adr_exp, din_exp, gv;
    @(negedge clk);
    g       = model_grant();
    we_exp  = (g == 0 && bus.we0) || (g == 1 && bus.we1);
    adr_exp = (g == 1) ? 32'(bus.adr1) : 32'(bus.adr0);
    din_exp = (g == 1) ? bus.din1 : bus.din0;
    chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
    chk("mem_we", 32'(bus.mem_we), 32'(we_exp));
    chk("mem_adr", 32'(bus.mem_adr), adr_exp);
    chk("mem_din", bus.mem_din, din_exp);
    if (exp_g != -2) begin
      gv = (exp_g == 0) ? 32'd1 : (exp_g == 1) ? 32'd2 : 32'd0;
      chk("directed_gnt", {30'b0, bus.gnt1, bus.gnt0}, gv);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stall0", 32'(stall0), 32'(m_stall0));
    chk("stall1", 32'(stall1), 32'(m_stall1));
`endif
    @(posedge clk);
    model_update(g);
    #1;
    chk("ack0", 32'(bus.ack0), 32'(m_ack0));
    chk("ack1", 32'(bus.ack1), 32'(m_ack1));
    chk("rdata0", bus.rdata0, m_rd0);
    chk("rdata1", bus.rdata1, m_rd1);
  endtask

  task automatic set0(input logic r, input logic w, input logic l, input logic [7:0] a,
                      input logic [31:0] d);
    bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.adr0 = a; bus.din0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [7:0] a,
                      input logic [31:0] d);
    bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.adr1 = a; bus.din1 = d;
  endtask

  initial begin
    int t4 [6];
    t4 = '{1, 1, 1, 1, -1, 0};

    // Writes requested during reset must never reach memory.
    rst = 1'b0;
    set0(1'b1, 1'b1, 1'b0, 8'd0, 32'd7);
    set1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    cycle(-1);
    cycle(-1);
    chk("t1_mem0", mem[0], 32'd0);
    chk("t1_ack0", 32'(bus.ack0), 32'd0);

    // Write then read back through requester 0.
    rst = 1'b1;
    set0(1'b1, 1'b1, 1'b0, 8'd1, 32'd22);
    cycle(0);
    chk("t2_ack_wr", 32'(bus.ack0), 32'd1);
    set0(1'b1, 1'b0, 1'b0, 8'd1, 32'd0);
    cycle(0);
    chk("t2_rdata0", bus.rdata0, 32'd22);
    set0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    cycle(-1);

    // Fresh reset, then both reading: strict alternation starting with 0.
    rst = 1'b0;
    cycle(-1);
    rst = 1'b1;
    set0(1'b1, 1'b0, 1'b0, 8'd1, 32'd0);
    set1(1'b1, 1'b0, 1'b0, 8'd5, 32'd0);
    cycle(0);
    cycle(1);
    cycle(0);
    cycle(1);

    // Requester 0 wins once so requester 1 takes the next tie, then a capped locked burst.
    set1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    cycle(0);
    set0(1'b1, 1'b0, 1'b0, 8'd4, 32'd0);
    for (int i = 0; i < 6; i++) begin
      set1(1'b1, 1'b1, 1'b1, 8'(8 + i), 32'(100 + i));
      cycle(t4[i]);
    end

    // Locked owner drops its request: one bubble before the other side is served.
    set1(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    set0(1'b1, 1'b1, 1'b1, 8'd20, 32'd55);
    cycle(0);
    set0(1'b1, 1'b1, 1'b1, 8'd20, 32'd56);
    cycle(0);
    set0(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    set1(1'b1, 1'b0, 1'b0, 8'd20, 32'd0);
    cycle(-1);
    cycle(1);
    chk("t5_rdata1", bus.rdata1, 32'd56);

    // Reset in the middle of a locked write burst.
    set1(1'b1, 1'b1, 1'b1, 8'd3, 32'd99);
    cycle(1);
    set1(1'b1, 1'b1, 1'b1, 8'd2, 32'd23);
    rst = 1'b0;
    cycle(-1);
    chk("t6_mem2", mem[2], 32'd0);
    rst = 1'b1;
    set0(1'b1, 1'b0, 1'b0, 8'd3, 32'd0);
    set1(1'b1, 1'b0, 1'b0, 8'd2, 32'd0);
    cycle(0);
    chk("t6_rdata0", bus.rdata0, 32'd99);
    cycle(1);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 15)), $urandom);
      set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 15)), $urandom);
      cycle(-2);
    end

    for (int a = 0; a < 256; a++) chk("mem_final", mem[a], ref_mem[a]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
